// File: rtl/thor2024_regfile_mp.sv
// thor2024_regfile_mp: multi-port register file for the wide-issue Thor2024 core.
// NWR write banks, each replicated NRD times so every read port has its own
// copy. A per-byte live value table picks the bank holding the newest byte.
// After reset, a sweep writes zero to every register before normal operation.

// One distributed-RAM copy: single byte-enabled write port, async read port.
module thor2024_regfile_mp_ram #(
  parameter int WID   = 64,
  parameter int DEP   = 256,
  parameter int AW    = $clog2(DEP),
  parameter int NLANE = WID/8
) (
  input  logic             clk,
  input  logic [NLANE-1:0] we,
  input  logic [AW-1:0]    wa,
  input  logic [WID-1:0]   wd,
  input  logic [AW-1:0]    ra,
  output logic [WID-1:0]   rd
);
  logic [WID-1:0] mem [DEP];

  // byte-lane write
  always_ff @(posedge clk)
    for (int l = 0; l < NLANE; l++)
      if (we[l]) mem[wa][l*8 +: 8] <= wd[l*8 +: 8];

  assign rd = mem[ra];
endmodule

module thor2024_regfile_mp #(
  parameter int WID    = 64,
  parameter int DEP    = 256,
  parameter int NWR    = 2,
  parameter int NRD    = 4,
  parameter int BYPASS = 1,
  parameter int R0ZERO = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NWR-1:0]               wr_en,
  input  logic [NWR*(WID/8)-1:0]       wr_be,
  input  logic [NWR*$clog2(DEP)-1:0]   wr_addr,
  input  logic [NWR*WID-1:0]           wr_data,
  input  logic [NRD-1:0]               rd_en,
  input  logic [NRD*$clog2(DEP)-1:0]   rd_addr,
  output logic [NRD*WID-1:0]           rd_data,
  output logic                         init_busy
);
  localparam int NLANE = WID/8;
  localparam int AW    = $clog2(DEP);
  localparam int LW    = (NWR > 1) ? $clog2(NWR) : 1;
  localparam logic [AW:0] CMAX = (AW+1)'(DEP-1);

  typedef enum logic {INIT, RUN} state_t;

  state_t  state, state_nx;
  logic [AW:0] cnt;
  logic        init;

  logic [NWR-1:0]                  wv;      // port write actually lands
  logic [NWR-1:0][NLANE-1:0]       ram_we;
  logic [NWR-1:0][AW-1:0]          ram_wa;
  logic [NWR-1:0][WID-1:0]         ram_wd;
  logic [NWR-1:0][NRD-1:0][WID-1:0] bank_q;
  logic [LW-1:0]                   lvt [DEP][NLANE];
  logic [NRD-1:0][WID-1:0]         rd_nx, rd_q;

  assign init      = (state == INIT);
  assign init_busy = init;

  // state and sweep counter; counter parks at DEP-1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (init && cnt != CMAX) cnt <= cnt + 1'b1;
    end

  // next state: leave the sweep after the last address is cleared
  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (cnt == CMAX) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  // write qualification and RAM port muxing (sweep overrides user writes)
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wv[p] = wr_en[p] && !init &&
              !((R0ZERO != 0) && (wr_addr[p*AW +: AW] == '0));
      if (init) begin
        ram_we[p] = '1;
        ram_wa[p] = cnt[AW-1:0];
        ram_wd[p] = '0;
      end else begin
        ram_we[p] = wv[p] ? wr_be[p*NLANE +: NLANE] : '0;
        ram_wa[p] = wr_addr[p*AW +: AW];
        ram_wd[p] = wr_data[p*WID +: WID];
      end
    end
  end

  for (genvar p = 0; p < NWR; p++) begin : g_bank
    for (genvar r = 0; r < NRD; r++) begin : g_copy
      thor2024_regfile_mp_ram #(.WID(WID), .DEP(DEP)) u_ram (
        .clk (clk),
        .we  (ram_we[p]),
        .wa  (ram_wa[p]),
        .wd  (ram_wd[p]),
        .ra  (rd_addr[r*AW +: AW]),
        .rd  (bank_q[p][r])
      );
    end
  end

  // LVT update; later ports overwrite earlier ones so the highest port wins
  always_ff @(posedge clk)
    if (init) begin
      for (int l = 0; l < NLANE; l++) lvt[cnt[AW-1:0]][l] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        for (int l = 0; l < NLANE; l++)
          if (wv[p] && wr_be[p*NLANE + l])
            lvt[wr_addr[p*AW +: AW]][l] <= LW'(p);
    end

  // read mux: LVT-selected bank, optional same-cycle bypass, zero register
  always_comb begin
    logic [AW-1:0] ra;
    logic [LW-1:0] sel;
    rd_nx = '0;
    ra    = '0;
    sel   = '0;
    for (int r = 0; r < NRD; r++) begin
      ra = rd_addr[r*AW +: AW];
      for (int l = 0; l < NLANE; l++) begin
        sel = lvt[ra][l];
        rd_nx[r][l*8 +: 8] = bank_q[sel][r][l*8 +: 8];
        if (BYPASS != 0)
          for (int p = 0; p < NWR; p++)
            if (wv[p] && wr_addr[p*AW +: AW] == ra && wr_be[p*NLANE + l])
              rd_nx[r][l*8 +: 8] = wr_data[p*WID + l*8 +: 8];
        if ((R0ZERO != 0) && ra == '0) rd_nx[r][l*8 +: 8] = '0;
      end
    end
  end

  // registered read data; forced to zero while sweeping, held when not enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    rd_q <= '0;
    else if (init) rd_q <= '0;
    else
      for (int r = 0; r < NRD; r++)
        if (rd_en[r]) rd_q[r] <= rd_nx[r];

  assign rd_data = rd_q;
endmodule
